// File: rtl/conv_stream_unit_if.sv
// Pixel, kernel-load and result signals of one conv_stream_unit.
// The master drives pixels/weights; the slave (the unit) returns results and status flags.
interface conv_stream_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic [DATA_WIDTH-1:0] psum_in;
    logic                  frame_clear;
    logic                  wt_valid;
    logic [DATA_WIDTH-1:0] wt_data;
    logic                  wt_commit;
    logic                  wt_full;
    logic                  wt_error;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  sat_flag;

    modport master (
        output pix_valid, pix_data, psum_in, frame_clear, wt_valid, wt_data, wt_commit,
        input  wt_full, wt_error, out_valid, out_data, out_last, sat_flag
    );

    modport slave (
        input  pix_valid, pix_data, psum_in, frame_clear, wt_valid, wt_data, wt_commit,
        output wt_full, wt_error, out_valid, out_data, out_last, sat_flag
    );
endinterface

// File: rtl/conv_stream_unit.sv
// KxK streaming convolution with double-buffered kernel, cascaded psum, round/saturate/ReLU.
// Result 2 cycles after the window-completing pixel; no backpressure, every valid pixel is taken.
module conv_stream_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int IFM_SIZE    = 14,
    parameter int KERNAL_SIZE = 5,
    parameter int STRIDE      = 1,
    parameter int RELU        = 0,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(KERNAL_SIZE*KERNAL_SIZE) + 1
) (
    input  logic              clk,
    input  logic              reset,
    conv_stream_unit_if.slave bus
);
    localparam int K   = KERNAL_SIZE;
    localparam int K2  = K*K;
    localparam int WIN = (K-1)*IFM_SIZE + K;
    localparam int CW  = $clog2(IFM_SIZE);
    localparam int AW  = $clog2(K2);
    localparam int IW  = $clog2(K2+1);
    localparam int PW  = 2*DATA_WIDTH;

    typedef logic signed [DATA_WIDTH-1:0] word_t;
    typedef logic signed [PW-1:0]         prod_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;

    localparam logic [CW-1:0] EDGE = CW'(IFM_SIZE-1);
    localparam logic [CW-1:0] KM1  = CW'(K-1);
    localparam logic [CW-1:0] STR  = CW'(STRIDE);
    localparam logic [IW-1:0] KCNT = IW'(K2);
    localparam acc_t          RND     = (acc_t'(1) <<< FRAC_BITS) >>> 1;
    localparam acc_t          SAT_MAX = acc_t'({(DATA_WIDTH-1){1'b1}});
    localparam acc_t          SAT_MIN = ~SAT_MAX;

    // The incoming pixel is window tap 0, so only WIN-1 words are stored.
    word_t lb  [WIN-1];
    word_t win [WIN];

    always_comb begin
        win[0] = bus.pix_data;
        for (int n = 1; n < WIN; n++) win[n] = lb[n-1];
    end

    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            lb[0] <= bus.pix_data;
            for (int n = 1; n < WIN-1; n++) lb[n] <= lb[n-1];
        end
    end

    // Position counters; frame_clear makes the pixel of this cycle (0,0).
    logic [CW-1:0] row, col, cur_row, cur_col, row_off, col_off;
    logic          fire, fire_last;

    assign cur_row   = bus.frame_clear ? '0 : row;
    assign cur_col   = bus.frame_clear ? '0 : col;
    assign row_off   = cur_row - KM1;
    assign col_off   = cur_col - KM1;
    assign fire      = bus.pix_valid && (cur_row >= KM1) && (cur_col >= KM1) &&
                       ((row_off % STR) == '0) && ((col_off % STR) == '0);
    assign fire_last = fire && (cur_row == EDGE) && (cur_col == EDGE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (bus.pix_valid) begin
            if (cur_col == EDGE) begin
                col <= '0;
                row <= (cur_row == EDGE) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end else if (bus.frame_clear) begin
            row <= '0;
            col <= '0;
        end
    end

    // Shadow/active kernel; a commit takes effect for windows after the commit cycle.
    word_t         shadow [K2];
    word_t         active [K2];
    logic [IW-1:0] wr_idx;
    logic          wt_full, wt_err;

    assign wt_full = (wr_idx == KCNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_idx <= '0;
            wt_err <= 1'b0;
            for (int k = 0; k < K2; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else if (bus.wt_commit && wt_full) begin
            active <= shadow;
            if (bus.wt_valid) begin
                shadow[0] <= bus.wt_data;
                wr_idx    <= IW'(1);
            end else begin
                wr_idx    <= '0;
            end
        end else begin
            if (bus.wt_commit) wt_err <= 1'b1;
            if (bus.wt_valid) begin
                if (wt_full) begin
                    wt_err <= 1'b1;
                end else begin
                    shadow[wr_idx[AW-1:0]] <= bus.wt_data;
                    wr_idx                 <= wr_idx + 1'b1;
                end
            end
        end
    end

    // Stage 1: products of window (i,j) against weight i*K+j.
    prod_t prod [K2];
    word_t psum_r;
    logic  vld1, last1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld1   <= 1'b0;
            last1  <= 1'b0;
            psum_r <= '0;
            for (int k = 0; k < K2; k++) prod[k] <= '0;
        end else begin
            vld1  <= fire;
            last1 <= fire_last;
            if (fire) begin
                psum_r <= bus.psum_in;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        prod[i*K+j] <= prod_t'(win[(K-1-i)*IFM_SIZE + (K-1-j)]) *
                                       prod_t'(active[i*K+j]);
                    end
                end
            end
        end
    end

    // Stage 2: sum, round half-up, saturate, optional ReLU.
    acc_t  acc, rnd;
    logic  clip_hi, clip_lo, relu_zero;
    word_t sat_val;

    always_comb begin
        acc = acc_t'(psum_r) <<< FRAC_BITS;
        for (int k = 0; k < K2; k++) acc = acc + acc_t'(prod[k]);
        rnd       = (acc + RND) >>> FRAC_BITS;
        clip_hi   = (rnd > SAT_MAX);
        clip_lo   = (rnd < SAT_MIN);
        sat_val   = clip_hi ? word_t'(SAT_MAX) : clip_lo ? word_t'(SAT_MIN) : word_t'(rnd);
        relu_zero = (RELU != 0) && sat_val[DATA_WIDTH-1];
    end

    logic  out_valid, out_last, sat_flag;
    word_t out_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= vld1;
            out_last  <= vld1 && last1;
            if (vld1) begin
                out_data <= relu_zero ? '0 : sat_val;
                if (clip_hi || (clip_lo && RELU == 0)) sat_flag <= 1'b1;
            end
        end
    end

    assign bus.wt_full   = wt_full;
    assign bus.wt_error  = wt_err;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.sat_flag  = sat_flag;
endmodule

// File: doc/conv_stream_unit.md
Name: conv_stream_unit

Overview:
Parametrised streaming convolution unit: one input channel, one kernel, any odd or even KERNAL_SIZE, configurable stride. It holds a KxK window over a row-major pixel stream, multiplies it against a double-buffered kernel, adds a cascaded partial sum, then rounds, saturates and optionally applies ReLU. Units are chained through psum_in/out_data to accumulate across IFM_DEPTH channels. It replaces the fixed 5x5, single-buffered conv units in the LeNet datapath.

Parameters:
DATA_WIDTH, 32, signed fixed-point word width of pixels, weights, psum and output
FRAC_BITS, 16, fractional bits of every word (Q format)
IFM_SIZE, 14, input feature-map width and height
KERNAL_SIZE, 5, kernel width and height (2..IFM_SIZE)
STRIDE, 1, output stride in both dimensions (1 or 2)
RELU, 0, 1 = clamp negative results to 0
ACC_WIDTH, 2*DATA_WIDTH+$clog2(KERNAL_SIZE*KERNAL_SIZE)+1, internal accumulator width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
pix_valid  in  1  pix_data valid this cycle
pix_data  in  DATA_WIDTH  input pixel, row-major order
psum_in  in  DATA_WIDTH  partial sum, sampled with the pixel that completes a window
frame_clear  in  1  restart row/col counters (pipeline drains normally)
wt_valid  in  1  write wt_data into the shadow kernel
wt_data  in  DATA_WIDTH  weight; first word = top-left, row-major
wt_commit  in  1  copy shadow kernel to active kernel
wt_full  out  1  shadow holds KERNAL_SIZE^2 weights
wt_error  out  1  sticky: commit while shadow incomplete, or write while full
out_valid  out  1  out_data valid
out_data  out  DATA_WIDTH  convolution result
out_last  out  1  with the final output of a frame
sat_flag  out  1  sticky: saturation occurred

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0. Counters, pipeline, shadow and active kernels, and the write index are cleared to 0. Reset mid-frame discards the partial frame.
- Line buffer depth (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE. It shifts only on pix_valid. Gaps of any length are legal.
- col/row counters advance on pix_valid. col wraps at IFM_SIZE-1 and row increments. Both wrap to 0 after pixel IFM_SIZE^2-1. frame_clear zeroes them in the same cycle; frame_clear takes precedence over a simultaneous pix_valid, which is still shifted in as pixel (0,0).
- Window fires on the accepting cycle t when row>=K-1, col>=K-1, (row-K+1)%STRIDE==0 and (col-K+1)%STRIDE==0. Window element (i,j) = pixel (row-K+1+i, col-K+1+j), multiplied by weight i*K+j.
- Pipeline:
  - Cycle t+1: K^2 products registered; psum_in captured at t.
  - Cycle t+2: out_valid=1 for exactly one cycle with the result.
  - out_last=1 with the output whose window ends at pixel (IFM_SIZE-1, IFM_SIZE-1) when that window fires.
- Arithmetic:
  - Products are full 2*DATA_WIDTH. Sum in ACC_WIDTH, plus (psum_in <<< FRAC_BITS).
  - Round half-up: add 1<<(FRAC_BITS-1), then arithmetic shift right FRAC_BITS. When FRAC_BITS=0, no rounding.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1]. Set sat_flag on clip.
  - If RELU=1, apply ReLU after saturation. Negative results become 0 and do not set sat_flag.
- Kernel load:
  - wt_valid writes the shadow at the write index, then increments it.
  - wt_full=1 when index==K^2. A write while full is dropped and sets wt_error.
  - wt_commit with wt_full=1 copies shadow to active and resets the index to 0. Windows firing on the same cycle use the old kernel; later windows use the new one.
  - wt_commit with wt_full=0 is ignored and sets wt_error.
  - wt_valid together with a successful wt_commit lands at index 0 after the commit.
- Sticky flags clear only on reset.

Test Plan:
- K=3, IFM_SIZE=5, FRAC_BITS=0, STRIDE=1, all weights 1, psum 0, pixels 1..25 -> 9 outputs. First output is 63, two cycles after pixel 13. Last output is 171 with out_last=1. No other out_last.
- Same setup with STRIDE=2 -> exactly 4 outputs: 63, 81, 153, 171. out_last on 171.
- Random pix_valid gaps plus psum_in=100 -> same sequence as STRIDE=1 offset by +100. Latency stays 2 cycles after the completing pixel.
- DATA_WIDTH=8, FRAC_BITS=0, weights 127, pixels 127 -> out 127, sat_flag=1. Pixels -128 -> out -128. RELU=1 with negative input -> out 0, sat_flag stays 0.
- Load kernel A, commit, stream half a frame, load kernel B, commit mid-frame -> outputs switch exactly at windows after the commit cycle. Commit after 8 writes -> wt_error=1, active kernel unchanged. A 10th write -> dropped, wt_error=1.
- Assert reset low mid-frame, then stream a fresh frame -> no stale outputs, and all outputs are 0 until a kernel is committed. frame_clear mid-frame -> next pixel treated as (0,0).
